// File: rtl/alu_ctrl_seq.sv
// Registered ALU-control decoder with a valid/ready handshake.
// HI/LO-class ops are held off while a MULT/DIV result is still pending.
module alu_ctrl_seq #(
  parameter int CTRL_W      = 5,
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             aluop,
  input  logic [5:0]             funct,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CTRL_W-1:0]      alucontrol,
  output logic                   out_illegal,
  output logic                   out_muldiv,
  output logic                   md_busy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int BUSY_W = $clog2(DIV_CYCLES + 1);
  // The accept cycle itself counts as the first busy cycle, so a dependent
  // HI/LO op can be accepted exactly MULT_CYCLES/DIV_CYCLES cycles later.
  localparam logic [BUSY_W-1:0] MULT_LOAD = BUSY_W'(MULT_CYCLES - 1);
  localparam logic [BUSY_W-1:0] DIV_LOAD  = BUSY_W'(DIV_CYCLES - 1);

  logic [4:0]             dec_code;
  logic                   dec_illegal;
  logic                   dec_hilo;
  logic                   dec_mul;
  logic                   dec_div;
  logic                   hz;
  logic                   acc;

  logic                   out_valid_q,   out_valid_d;
  logic [CTRL_W-1:0]      alucontrol_q,  alucontrol_d;
  logic                   out_illegal_q, out_illegal_d;
  logic                   out_muldiv_q,  out_muldiv_d;
  logic [BUSY_W-1:0]      busy_q,        busy_d;
  logic [STALL_CNT_W-1:0] stall_q,       stall_d;

  always_comb begin
    dec_code    = 5'b00000;
    dec_illegal = 1'b0;
    dec_hilo    = 1'b0;
    dec_mul     = 1'b0;
    dec_div     = 1'b0;
    case (aluop)
      2'b00: dec_code = 5'b01110;
      2'b01: dec_code = 5'b01111;
      2'b10: begin
        case (funct)
          6'b000000: dec_code = 5'b00000;
          6'b000010: dec_code = 5'b00001;
          6'b000011: dec_code = 5'b00010;
          6'b000100: dec_code = 5'b00011;
          6'b000110: dec_code = 5'b00100;
          6'b000111: dec_code = 5'b00101;
          6'b001000: dec_code = 5'b00110;
          6'b001001: dec_code = 5'b00111;
          6'b010001: begin dec_code = 5'b01000; dec_hilo = 1'b1; end
          6'b010011: begin dec_code = 5'b01001; dec_hilo = 1'b1; end
          6'b011000: begin dec_code = 5'b01010; dec_hilo = 1'b1; dec_mul = 1'b1; end
          6'b011001: begin dec_code = 5'b01011; dec_hilo = 1'b1; dec_mul = 1'b1; end
          6'b011010: begin dec_code = 5'b01100; dec_hilo = 1'b1; dec_div = 1'b1; end
          6'b011011: begin dec_code = 5'b01101; dec_hilo = 1'b1; dec_div = 1'b1; end
          6'b100001: dec_code = 5'b01110;
          6'b100011: dec_code = 5'b01111;
          6'b100100: dec_code = 5'b10000;
          6'b100101: dec_code = 5'b10001;
          6'b100110: dec_code = 5'b10010;
          6'b101010: dec_code = 5'b10011;
          6'b101011: dec_code = 5'b10100;
          6'b010000: begin dec_code = 5'b10101; dec_hilo = 1'b1; end
          6'b010010: begin dec_code = 5'b10110; dec_hilo = 1'b1; end
          default:   dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign md_busy  = (busy_q != '0);
  assign hz       = md_busy && dec_hilo;
  assign in_ready = (!out_valid_q || out_ready) && !hz;
  assign acc      = in_valid && in_ready;

  always_comb begin
    out_valid_d   = out_valid_q;
    alucontrol_d  = alucontrol_q;
    out_illegal_d = out_illegal_q;
    out_muldiv_d  = out_muldiv_q;
    busy_d        = busy_q;
    stall_d       = stall_q;

    if (acc) begin
      out_valid_d   = 1'b1;
      alucontrol_d  = CTRL_W'(dec_code);
      out_illegal_d = dec_illegal;
      out_muldiv_d  = dec_mul || dec_div;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // MULT/DIV cannot be accepted while busy, so load and decrement are exclusive.
    if (acc && dec_mul) begin
      busy_d = MULT_LOAD;
    end else if (acc && dec_div) begin
      busy_d = DIV_LOAD;
    end else if (busy_q != '0) begin
      busy_d = busy_q - BUSY_W'(1);
    end

    if (in_valid && hz && (stall_q != '1)) begin
      stall_d = stall_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      alucontrol_q  <= '0;
      out_illegal_q <= 1'b0;
      out_muldiv_q  <= 1'b0;
      busy_q        <= '0;
      stall_q       <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      alucontrol_q  <= alucontrol_d;
      out_illegal_q <= out_illegal_d;
      out_muldiv_q  <= out_muldiv_d;
      busy_q        <= busy_d;
      stall_q       <= stall_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign alucontrol  = alucontrol_q;
  assign out_illegal = out_illegal_q;
  assign out_muldiv  = out_muldiv_q;
  assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: directed scenarios followed by random traffic, all
// checked against a cycle-indexed reference model (HI/LO free-at-cycle timestamp).
module tb_alu_ctrl_seq;

  localparam int CTRL_W      = 5;
  localparam int MULT_CYCLES = 4;
  localparam int DIV_CYCLES  = 32;
  localparam int STALL_CNT_W = 16;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   in_valid;
  logic                   in_ready;
  logic [1:0]             aluop;
  logic [5:0]             funct;
  logic                   out_valid;
  logic                   out_ready;
  logic [CTRL_W-1:0]      alucontrol;
  logic                   out_illegal;
  logic                   out_muldiv;
  logic                   md_busy;
  logic [STALL_CNT_W-1:0] stall_cnt;

  alu_ctrl_seq #(
    .CTRL_W(CTRL_W), .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES(DIV_CYCLES), .STALL_CNT_W(STALL_CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .aluop(aluop), .funct(funct), .out_valid(out_valid), .out_ready(out_ready),
    .alucontrol(alucontrol), .out_illegal(out_illegal), .out_muldiv(out_muldiv),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: HI/LO is free from cycle m_free onwards.
  longint  cyc = 0;
  longint  m_free = 0;
  bit      m_valid = 0;
  int      m_code = 0;
  bit      m_ill = 0;
  bit      m_md = 0;
  int      m_stall = 0;
  bit      last_acc = 0;

  int fn_tab[23]   = '{6'o00, 6'o02, 6'o03, 6'o04, 6'o06, 6'o07, 6'o10, 6'o11,
                       6'o21, 6'o23, 6'o30, 6'o31, 6'o32, 6'o33, 6'o41, 6'o43,
                       6'o44, 6'o45, 6'o46, 6'o52, 6'o53, 6'o20, 6'o22};
  int hilo_tab[8]  = '{6'o20, 6'o21, 6'o22, 6'o23, 6'o30, 6'o31, 6'o32, 6'o33};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Table position i holds the funct whose ALU code is i.
  task automatic ref_decode(input logic [1:0] a, input logic [5:0] f,
                            output int code, output bit ill, output bit hilo,
                            output bit mul, output bit dv);
    code = 0; ill = 1; hilo = 0; mul = 0; dv = 0;
    if (a == 2'b00) begin code = 14; ill = 0; end
    else if (a == 2'b01) begin code = 15; ill = 0; end
    else if (a == 2'b10) begin
      for (int i = 0; i < 23; i++)
        if (fn_tab[i] == int'(f)) begin code = i; ill = 0; end
      for (int i = 0; i < 8; i++)
        if (hilo_tab[i] == int'(f)) hilo = 1;
      mul = (f == 6'o30) || (f == 6'o31);
      dv  = (f == 6'o32) || (f == 6'o33);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid",   32'(out_valid),   32'(m_valid));
    chk("alucontrol",  32'(alucontrol),  32'(m_code));
    chk("out_illegal", 32'(out_illegal), 32'(m_ill));
    chk("out_muldiv",  32'(out_muldiv),  32'(m_md));
    chk("md_busy",     32'(md_busy),     32'(cyc < m_free));
    chk("stall_cnt",   32'(stall_cnt),   32'(m_stall));
  endtask

  task automatic step(input logic v, input logic [1:0] a, input logic [5:0] f, input logic r);
    int code; bit ill, hilo, mul, dv, blocked, e_rdy;
    in_valid = v; aluop = a; funct = f; out_ready = r;
    @(negedge clk);
    ref_decode(a, f, code, ill, hilo, mul, dv);
    blocked = hilo && (cyc < m_free);
    e_rdy = (!m_valid || r) && !blocked;
    check_outputs();
    chk("in_ready", 32'(in_ready), 32'(e_rdy));
    if (v && blocked && m_stall != (1 << STALL_CNT_W) - 1) m_stall++;
    last_acc = v && e_rdy;
    if (last_acc) begin
      m_valid = 1; m_code = code; m_ill = ill; m_md = mul || dv;
      if (mul) m_free = cyc + MULT_CYCLES;
      if (dv)  m_free = cyc + DIV_CYCLES;
    end else if (m_valid && r) begin
      m_valid = 0;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic step_reset(input logic v, input logic [1:0] a, input logic [5:0] f);
    reset = 1'b1; in_valid = v; aluop = a; funct = f; out_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_valid = 0; m_code = 0; m_ill = 0; m_md = 0; m_stall = 0;
    cyc++; m_free = cyc;
  endtask

  initial begin
    int waited, s0;
    logic [1:0] ra;
    logic [5:0] rf;
    reset = 1'b1; in_valid = 1'b0; aluop = 2'b00; funct = 6'o00; out_ready = 1'b1;
    @(posedge clk); #1;
    step_reset(1'b0, 2'b00, 6'o00);
    step(1'b0, 2'b00, 6'o00, 1'b1);

    // 1: AND decode
    step(1'b1, 2'b10, 6'o44, 1'b1);
    chk("t1_code", 32'(alucontrol), 32'b10000);
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_illegal", 32'(out_illegal), 0);

    // 2: MULT then MFLO waits MULT_CYCLES-1 cycles
    step(1'b1, 2'b10, 6'o30, 1'b1);
    s0 = m_stall; waited = 0;
    step(1'b1, 2'b10, 6'o22, 1'b1);
    while (!last_acc && waited < 10) begin
      waited++;
      step(1'b1, 2'b10, 6'o22, 1'b1);
    end
    chk("t2_wait", 32'(waited), 3);
    chk("t2_stall", 32'(stall_cnt) - 32'(s0), 3);
    chk("t2_code", 32'(alucontrol), 32'b10110);

    // 3: DIV then ADDU flows freely; busy decays
    step(1'b1, 2'b10, 6'o32, 1'b1);
    step(1'b1, 2'b10, 6'o41, 1'b1);
    chk("t3_addu", 32'(alucontrol), 32'b01110);
    for (int i = 0; i < DIV_CYCLES + 2; i++) step(1'b0, 2'b00, 6'o00, 1'b1);
    chk("t3_idle", 32'(md_busy), 0);

    // 4: output held while out_ready low
    step(1'b1, 2'b10, 6'o03, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'b00, 6'o00, 1'b0);
      chk("t4_hold", 32'(alucontrol), 32'b00010);
    end
    step(1'b0, 2'b00, 6'o00, 1'b1);

    // 5: illegal encodings
    step(1'b1, 2'b11, 6'o44, 1'b1);
    chk("t5_op11_ill", 32'(out_illegal), 1);
    chk("t5_op11_code", 32'(alucontrol), 0);
    step(1'b1, 2'b10, 6'o77, 1'b1);
    chk("t5_fn77_ill", 32'(out_illegal), 1);
    step(1'b1, 2'b10, 6'o01, 1'b1);
    chk("t5_fn01_ill", 32'(out_illegal), 1);

    // 6: reset mid-DIV, MULT offered during reset is discarded
    step(1'b1, 2'b10, 6'o33, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 2'b00, 6'o00, 1'b1);
    step_reset(1'b1, 2'b10, 6'o30);
    step(1'b1, 2'b10, 6'o30, 1'b1);
    chk("t6_mult_acc", 32'(out_valid), 1);
    chk("t6_mult_code", 32'(alucontrol), 32'b01010);
    chk("t6_muldiv", 32'(out_muldiv), 1);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 3))
        0: begin ra = 2'b10; rf = 6'(fn_tab[$urandom_range(0, 22)]); end
        1: begin ra = 2'b10; rf = 6'(hilo_tab[$urandom_range(0, 7)]); end
        2: begin ra = 2'(int'($urandom)); rf = 6'(int'($urandom)); end
        default: begin ra = 2'(int'($urandom_range(0, 1))); rf = 6'(int'($urandom)); end
      endcase
      if ($urandom_range(0, 199) == 0)
        step_reset(1'($urandom), ra, rf);
      else
        step(1'($urandom_range(0, 4) != 0), ra, rf, 1'($urandom_range(0, 3) != 0));
    end
    step(1'b0, 2'b00, 6'o00, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
